shift_normalizer: RTL and testbench
===================================

# shift_normalizer

Multi-cycle normalizer for the execute stage: the inverse operation to the ALU shifter. Instead of applying a known shift amount, it recovers one. Given a 32-bit operand, it finds the shift amount that normalizes it (leading-zero count for left, trailing-zero count for right), and returns both the count and the normalized value. It is used for CLZ/CTZ-style operations and for operand normalization ahead of the multi-cycle datapath. It uses a fixed-latency, 5-step binary search with a start/busy/done handshake.

## Interface
- No parameters; data width fixed at 32, count width fixed at 6.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  32  operand; sampled on the accepting edge only.
- mode  input  1  0 = left normalize (count leading zeros); 1 = right normalize (count trailing zeros). Sampled with a.
- busy  output  1  high while a search is in progress.
- done  output  1  one-cycle pulse when result/count/zero become valid.
- result  output  32  normalized operand (left: MSB set; right: LSB set; 0 if operand was 0).
- count  output  6  shift amount applied, 0..32.
- zero  output  1  operand was all-zero.

## Operation
- States: IDLE, RUN, DONE.
- Reset (async): state=IDLE, busy=0, done=0, result=0, count=0, zero=0, internal step index=0.
- IDLE/DONE with start=1: latch a into the working register and latch mode. Set zero=(a==0) and count=0. Clear step index to 0 and go to RUN. busy=1 from the next cycle.
- RUN performs one step per cycle, with step sizes 16, 8, 4, 2, 1 (index 0..4):
  - mode 0: if the top k bits of the working register are all zero, the register becomes register << k and count += k.
  - mode 1: if the bottom k bits are all zero, the register becomes register >> k (logical, zero fill) and count += k.
  - Otherwise the register and count are unchanged.
- After step index 4: go to DONE. result = working register. count = 32 if zero is latched, otherwise the accumulated count. done=1 and busy=0 for exactly that cycle.
- DONE with start=0 goes to IDLE. done falls. result, count and zero hold their values until the next accepted start.
- Arithmetic: count accumulates in 6 bits. The maximum non-zero-operand count is 31, so there is no overflow. The value 32 is produced only by the zero override.
- start while busy=1 is ignored. Operand and mode changes during RUN have no effect.
- a and mode are don't-care except on the accepting edge.

## Timing
- Accepting edge E0 (start=1, busy=0). Steps occur on edges E1..E5. done=1 in the cycle following E5.
- Latency: done asserts 6 cycles after start is presented, and is constant for all operands and modes.
- Throughput: one operation per 6 cycles. start held high continuously in DONE is accepted on that DONE edge (back-to-back), and done pulses only once per operation.
- done is never high for two consecutive cycles. busy and done are never both high.
- result, count and zero are stable whenever busy=0. Between E0 and done they are don't-care and must not be used.
- Reset asserted mid-RUN: outputs return to reset values immediately (asynchronously), with no done pulse. The first start after rst deasserts begins a fresh operation.

## Test plan
- Left, mid value: a=0x00010000, mode=0 → done 6 cycles after start, result=0x80000000, count=15, zero=0.
- Left and right boundaries:
  - a=0x80000000, mode=0 → result=0x80000000, count=0.
  - a=0x00000001, mode=0 → result=0x80000000, count=31.
- Right: a=0x00000100, mode=1 → result=0x00000001, count=8. a=0xFFFFFFFF, mode=1 → result=0xFFFFFFFF, count=0.
- Zero operand, both modes: a=0 → result=0, count=32, zero=1. A following a=0x40000000, mode=0 → count=1, zero=0.
- Handshake:
  - Pulse start again 2 cycles into RUN with a different a → the pulse is ignored, and the first result is returned unchanged.
  - start held high across DONE → second operation accepted, with exactly one done pulse per operation.
- Reset mid-operation: assert rst at cycle 3 of RUN → busy, done, result, count and zero go to 0 immediately, with no done pulse. After rst is released, a=0x0000F000, mode=1 → count=12, result=0x0000000F.

Source files
------------

// File: rtl/shift_normalizer.sv
// Multi-cycle normalizer: recovers the leading/trailing zero count of a 32-bit
// operand by a fixed 5-step binary search (16, 8, 4, 2, 1), with start/busy/done.
module shift_normalizer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic        mode,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [5:0]  count,
  output logic        zero
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] work_q, work_d;
  logic [5:0]  count_q, count_d;
  logic        zero_q, zero_d;
  logic        mode_q, mode_d;
  logic [2:0]  step_q, step_d;
  logic [5:0]  k_w;

  // Are the top (left) or bottom (right) 16>>s bits of v all zero?
  function automatic logic top_zero(input logic [31:0] v, input logic [2:0] s);
    case (s)
      3'd0:    top_zero = (v[31:16] == 16'd0);
      3'd1:    top_zero = (v[31:24] == 8'd0);
      3'd2:    top_zero = (v[31:28] == 4'd0);
      3'd3:    top_zero = (v[31:30] == 2'd0);
      default: top_zero = ~v[31];
    endcase
  endfunction

  function automatic logic bottom_zero(input logic [31:0] v, input logic [2:0] s);
    case (s)
      3'd0:    bottom_zero = (v[15:0] == 16'd0);
      3'd1:    bottom_zero = (v[7:0] == 8'd0);
      3'd2:    bottom_zero = (v[3:0] == 4'd0);
      3'd3:    bottom_zero = (v[1:0] == 2'd0);
      default: bottom_zero = ~v[0];
    endcase
  endfunction

  assign k_w = 6'd16 >> step_q;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    count_d = count_q;
    zero_d  = zero_q;
    mode_d  = mode_q;
    step_d  = step_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          work_d  = a;
          mode_d  = mode;
          zero_d  = (a == 32'd0);
          count_d = 6'd0;
          step_d  = 3'd0;
          state_d = ST_RUN;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!mode_q && top_zero(work_q, step_q)) begin
          work_d  = work_q << k_w;
          count_d = count_q + k_w;
        end else if (mode_q && bottom_zero(work_q, step_q)) begin
          work_d  = work_q >> k_w;
          count_d = count_q + k_w;
        end
        step_d = step_q + 3'd1;
        if (step_q == 3'd4) begin
          state_d = ST_DONE;
          // A zero operand accumulates 31; report the full width instead.
          if (zero_q) count_d = 6'd32;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      work_q  <= 32'd0;
      count_q <= 6'd0;
      zero_q  <= 1'b0;
      mode_q  <= 1'b0;
      step_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      count_q <= count_d;
      zero_q  <= zero_d;
      mode_q  <= mode_d;
      step_q  <= step_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign result = work_q;
  assign count  = count_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_shift_normalizer.sv
// Bench for shift_normalizer: directed operations with literal expectations,
// plus an arithmetic reference model checked against the outputs every cycle.
module tb_shift_normalizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = 32'd0;
  logic        mode = 1'b0;
  logic        busy, done, zero;
  logic [31:0] result;
  logic [5:0]  count;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  shift_normalizer dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .mode(mode),
    .busy(busy), .done(done), .result(result), .count(count), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference normalization by plain bit-at-a-time counting.
  function automatic void norm(input logic [31:0] v, input logic m,
                               output logic [31:0] r, output int c);
    r = v;
    c = 0;
    if (v == 32'd0) begin
      c = 32;
      return;
    end
    if (!m) while (!r[31]) begin r = r << 1; c++; end
    else    while (!r[0])  begin r = r >> 1; c++; end
  endfunction

  // Timing model: phase 0 = idle, 1..5 = searching, 6 = done cycle.
  int          m_phase = 0;
  logic [31:0] m_a = 32'd0;
  logic        m_mode = 1'b0;
  logic [31:0] m_res = 32'd0;
  int          m_cnt = 0;
  logic        m_zero = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_res   = 32'd0;
      m_cnt   = 0;
      m_zero  = 1'b0;
    end else if ((m_phase == 0 || m_phase == 6) && start) begin
      m_a     = a;
      m_mode  = mode;
      m_phase = 1;
    end else if (m_phase == 6) begin
      m_phase = 0;
    end else if (m_phase >= 1) begin
      m_phase++;
      if (m_phase == 6) begin
        norm(m_a, m_mode, m_res, m_cnt);
        m_zero = (m_a == 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model busy", {31'd0, busy}, {31'd0, (m_phase >= 1 && m_phase <= 5)});
      check("model done", {31'd0, done}, {31'd0, (m_phase == 6)});
      if (m_phase == 0 || m_phase == 6) begin
        check("model result", result, m_res);
        check("model count", {26'd0, count}, 32'(m_cnt));
        check("model zero", {31'd0, zero}, {31'd0, m_zero});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done after an accepting edge; returns cycles counted from E0.
  task automatic wait_done(input string name, output int cyc);
    cyc = 1;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: done not seen within 20 cycles", name);
    end
  endtask

  task automatic check_res(input string name, input logic [31:0] er,
                           input logic [5:0] ec, input logic ez, input int cyc);
    check({name, " latency"}, 32'(cyc), 32'd6);
    check({name, " result"}, result, er);
    check({name, " count"}, {26'd0, count}, {26'd0, ec});
    check({name, " zero"}, {31'd0, zero}, {31'd0, ez});
  endtask

  task automatic run_op(input string name, input logic [31:0] va, input logic vm,
                        input logic [31:0] er, input logic [5:0] ec, input logic ez);
    int cyc;
    start = 1'b1;
    a     = va;
    mode  = vm;
    tick();
    start = 1'b0;
    a     = $urandom;
    mode  = ~vm;
    wait_done(name, cyc);
    check_res(name, er, ec, ez, cyc);
    tick();
    check({name, " done falls"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    repeat (2) tick();
    chk_en = 1'b1;
    rst = 1'b0;
    tick();
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset count", {26'd0, count}, 32'd0);
    check("reset zero", {31'd0, zero}, 32'd0);

    run_op("left mid",  32'h0001_0000, 1'b0, 32'h8000_0000, 6'd15, 1'b0);
    run_op("left msb",  32'h8000_0000, 1'b0, 32'h8000_0000, 6'd0,  1'b0);
    run_op("left lsb",  32'h0000_0001, 1'b0, 32'h8000_0000, 6'd31, 1'b0);
    run_op("right 100", 32'h0000_0100, 1'b1, 32'h0000_0001, 6'd8,  1'b0);
    run_op("right ones", 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 6'd0, 1'b0);
    run_op("zero left", 32'h0000_0000, 1'b0, 32'h0000_0000, 6'd32, 1'b1);
    run_op("zero right", 32'h0000_0000, 1'b1, 32'h0000_0000, 6'd32, 1'b1);
    run_op("after zero", 32'h4000_0000, 1'b0, 32'h8000_0000, 6'd1, 1'b0);
    repeat (2) tick();
    check("idle hold count", {26'd0, count}, 32'd1);

    // start pulsed two cycles into the search must be ignored
    start = 1'b1; a = 32'h0000_0300; mode = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    start = 1'b1; a = 32'h0001_0000; mode = 1'b0;
    tick();
    start = 1'b0;
    cyc = 4;
    while (!done && cyc < 20) begin tick(); cyc++; end
    check_res("ignored start", 32'h0000_0003, 6'd8, 1'b0, cyc);
    tick();
    check("ignored start no rerun", {31'd0, busy}, 32'd0);

    // start held high across DONE: back-to-back operations
    start = 1'b1; a = 32'h0000_0001; mode = 1'b1;
    tick();
    a = 32'h00F0_0000; mode = 1'b0;
    wait_done("b2b first", cyc);
    check_res("b2b first", 32'h0000_0001, 6'd0, 1'b0, cyc);
    tick();
    start = 1'b0;
    check("b2b done single", {31'd0, done}, 32'd0);
    check("b2b busy again", {31'd0, busy}, 32'd1);
    wait_done("b2b second", cyc);
    check_res("b2b second", 32'hF000_0000, 6'd8, 1'b0, cyc);
    tick();

    // asynchronous reset during the search
    start = 1'b1; a = 32'h0000_0010; mode = 1'b0;
    tick();
    start = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst result", result, 32'd0);
    check("rst count", {26'd0, count}, 32'd0);
    check("rst zero", {31'd0, zero}, 32'd0);
    repeat (4) begin
      tick();
      check("rst no done", {31'd0, done}, 32'd0);
    end
    rst = 1'b0;
    tick();
    run_op("post rst", 32'h0000_F000, 1'b1, 32'h0000_000F, 6'd12, 1'b0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
